// File: rtl/mkgauss_cdt_mlane.sv
// rtl/mkgauss_cdt_mlane.sv - multi-lane CDT Gaussian sampler with runtime table and FWFT output FIFO
module mkgauss_cdt_mlane #(
    parameter int RNG_W      = 128,
    parameter int SAMP_W     = 24,
    parameter int LANES      = 4,
    parameter int TBL_N      = 18,
    parameter int FIFO_DEPTH = 8,
    parameter int OUT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     clr,
    input  logic                     signed_en,
    input  logic                     rng_valid,
    input  logic [RNG_W-1:0]         rng,
    output logic                     rng_ready,
    input  logic                     tbl_we,
    input  logic [$clog2(TBL_N)-1:0] tbl_addr,
    input  logic [SAMP_W-1:0]        tbl_wdata,
    input  logic                     extract,
    output logic                     val_valid,
    output logic [OUT_W-1:0]         val
);
    localparam int USED = LANES * (SAMP_W + 1);
    localparam int ZW   = $clog2(TBL_N + 1);
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    generate
        if (USED > RNG_W) begin : g_bad_lanes
            $error("mkgauss_cdt_mlane: LANES*(SAMP_W+1) exceeds RNG_W");
        end
        if (FIFO_DEPTH < LANES) begin : g_bad_depth
            $error("mkgauss_cdt_mlane: FIFO_DEPTH must be >= LANES");
        end
        if (USED < RNG_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^rng[RNG_W-1:USED];
        end
    endgenerate

    logic [SAMP_W-1:0] tbl [TBL_N];
    logic              s0_valid, s0_sen, s1_valid;
    logic [USED-1:0]   s0_rng;
    logic [OUT_W-1:0]  s1_samp [LANES];
    logic [OUT_W-1:0]  lane_samp [LANES];
    logic [ZW-1:0]     z [LANES];
    logic [OUT_W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [1:0]        pend;
    logic              fits, accept, pop, tbl_wr;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= FIFO_DEPTH) s = s - FIFO_DEPTH;
        return PW'(s);
    endfunction

    // Credit check reserves room for every word already in flight plus the one being offered.
    assign pend      = {1'b0, s0_valid} + {1'b0, s1_valid};
    assign fits      = (int'(count) + LANES * (int'(pend) + 1)) <= FIFO_DEPTH;
    assign rng_ready = rst_n & ena & ~clr & fits;
    assign accept    = rng_valid & rng_ready;
    assign val_valid = (count != '0);
    assign val       = val_valid ? mem[rd_ptr] : '0;
    assign pop       = extract & val_valid & ~clr;
    assign tbl_wr    = tbl_we & ~ena & (pend == 2'd0) & (int'(tbl_addr) < TBL_N);

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            z[k] = '0;
            for (int i = 0; i < TBL_N; i++) begin
                if (s0_rng[k*(SAMP_W+1) +: SAMP_W] < tbl[i]) z[k] = z[k] + ZW'(1);
            end
            lane_samp[k] = (s0_sen & s0_rng[k*(SAMP_W+1)+SAMP_W]) ? -OUT_W'(z[k]) : OUT_W'(z[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TBL_N; i++) tbl[i] <= '0;
            for (int k = 0; k < LANES; k++) s1_samp[k] <= '0;
            s0_valid <= 1'b0;
            s0_sen   <= 1'b0;
            s0_rng   <= '0;
            s1_valid <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (tbl_wr) tbl[tbl_addr] <= tbl_wdata;
            if (accept) begin
                s0_rng <= rng[USED-1:0];
                s0_sen <= signed_en;
            end
            if (s0_valid) s1_samp <= lane_samp;
            if (clr) begin
                s0_valid <= 1'b0;
                s1_valid <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                s0_valid <= accept;
                s1_valid <= s0_valid;
                if (pop) rd_ptr <= wrap_add(rd_ptr, 1);
                if (s1_valid) wr_ptr <= wrap_add(wr_ptr, LANES);
                count <= CW'(int'(count) + (s1_valid ? LANES : 0) - (pop ? 1 : 0));
            end
        end
    end

    // Sample storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (s1_valid && !clr) begin
            for (int k = 0; k < LANES; k++) mem[wrap_add(wr_ptr, k)] <= s1_samp[k];
        end
    end
endmodule

// File: tb/tb_mkgauss_cdt_mlane.sv
// tb/tb_mkgauss_cdt_mlane.sv - self-checking bench for mkgauss_cdt_mlane with queue-based reference model
module tb_mkgauss_cdt_mlane;
    localparam int RNG_W = 128, SAMP_W = 24, LANES = 4, TBL_N = 18, FIFO_DEPTH = 8, OUT_W = 32;

    logic clk = 1'b0;
    logic rst_n, ena, clr, signed_en, rng_valid, tbl_we, extract;
    logic rng_ready, val_valid;
    logic [RNG_W-1:0]  rng;
    logic [4:0]        tbl_addr;
    logic [SAMP_W-1:0] tbl_wdata;
    logic [OUT_W-1:0]  val;

    int n_chk = 0;
    int n_fail = 0;

    mkgauss_cdt_mlane #(
        .RNG_W(RNG_W), .SAMP_W(SAMP_W), .LANES(LANES),
        .TBL_N(TBL_N), .FIFO_DEPTH(FIFO_DEPTH), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr), .signed_en(signed_en),
        .rng_valid(rng_valid), .rng(rng), .rng_ready(rng_ready),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .extract(extract), .val_valid(val_valid), .val(val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table copy, FIFO contents as a queue, in-flight words with age in edges.
    typedef struct {
        logic [LANES*OUT_W-1:0] s;
        int                     age;
    } pw_t;

    logic [SAMP_W-1:0] tbl_m [TBL_N];
    logic [OUT_W-1:0]  mq [$];
    pw_t               pw [$];
    bit                m_acc, m_pop;
    pw_t               m_w;

    function automatic logic [OUT_W-1:0] cdt(input logic [SAMP_W-1:0] r, input bit s, input bit sen);
        int z;
        z = 0;
        for (int i = 0; i < TBL_N; i++) if (r < tbl_m[i]) z++;
        if (sen && s) z = -z;
        return OUT_W'(z);
    endfunction

    function automatic bit model_ready();
        return rst_n && ena && !clr && (mq.size() + LANES * (pw.size() + 1) <= FIFO_DEPTH);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            pw.delete();
            for (int i = 0; i < TBL_N; i++) tbl_m[i] = '0;
        end else begin
            m_acc = rng_valid && model_ready();
            m_pop = extract && (mq.size() != 0) && !clr;
            if (tbl_we && !ena && pw.size() == 0 && tbl_addr < TBL_N) tbl_m[tbl_addr] = tbl_wdata;
            if (clr) begin
                mq.delete();
                pw.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (pw.size() != 0 && pw[0].age == 1) begin
                    m_w = pw.pop_front();
                    for (int k = 0; k < LANES; k++) mq.push_back(m_w.s[k*OUT_W +: OUT_W]);
                end
                foreach (pw[j]) pw[j].age = pw[j].age + 1;
                if (m_acc) begin
                    for (int k = 0; k < LANES; k++)
                        m_w.s[k*OUT_W +: OUT_W] = cdt(rng[k*(SAMP_W+1) +: SAMP_W],
                                                      rng[k*(SAMP_W+1)+SAMP_W], signed_en);
                    m_w.age = 0;
                    pw.push_back(m_w);
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_val_valid", {63'd0, val_valid}, {63'd0, mq.size() != 0});
        chk("cyc_val", {32'd0, val}, {32'd0, (mq.size() != 0) ? mq[0] : 32'd0});
        chk("cyc_rng_ready", {63'd0, rng_ready}, {63'd0, model_ready()});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RNG_W-1:0] mk(input logic [4*SAMP_W-1:0] rs, input logic [3:0] ss);
        logic [RNG_W-1:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w[k*(SAMP_W+1) +: SAMP_W] = rs[k*SAMP_W +: SAMP_W];
            w[k*(SAMP_W+1) + SAMP_W]  = ss[k];
        end
        return w;
    endfunction

    task automatic load_table();
        for (int i = 0; i < TBL_N; i++) begin
            tbl_we    = 1'b1;
            tbl_addr  = 5'(i);
            tbl_wdata = SAMP_W'(32'h900000 - i * 32'h080000);
            step();
        end
        tbl_we = 1'b0;
    endtask

    task automatic send_timed(input logic [RNG_W-1:0] w, input bit sen);
        rng_valid = 1'b1;
        rng       = w;
        signed_en = sen;
        @(negedge clk); chk("lit_ready_before_accept", {63'd0, rng_ready}, 64'd1);
        step();
        rng_valid = 1'b0;
        @(negedge clk); chk("lit_vv_after_e0", {63'd0, val_valid}, 64'd0);
        step();
        @(negedge clk); chk("lit_vv_after_e1", {63'd0, val_valid}, 64'd0);
        step();
        @(negedge clk); chk("lit_vv_after_e2", {63'd0, val_valid}, 64'd1);
        step();
    endtask

    task automatic pop_expect(input logic [OUT_W-1:0] e [4]);
        extract = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("lit_pop_valid", {63'd0, val_valid}, 64'd1);
            chk("lit_pop_val", {32'd0, val}, {32'd0, e[j]});
            step();
        end
        extract = 1'b0;
    endtask

    task automatic drain(output int n);
        n = 0;
        extract = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (val_valid) n++;
            step();
        end
        extract = 1'b0;
    endtask

    logic [RNG_W-1:0] w_t2;
    logic [OUT_W-1:0] e_t2 [4];
    logic [OUT_W-1:0] e_t3 [4];
    int               acc, n;

    initial begin
        rst_n = 1'b0; ena = 1'b1; clr = 1'b0; signed_en = 1'b0; rng_valid = 1'b0; rng = '0;
        tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0; extract = 1'b0;
        w_t2 = mk({24'h7FFFFF, 24'h500000, 24'h900000, 24'h000000}, 4'b1100);
        e_t2[0] = 32'd18; e_t2[1] = 32'd0; e_t2[2] = -32'sd8; e_t2[3] = -32'sd3;
        e_t3[0] = 32'd18; e_t3[1] = 32'd0; e_t3[2] = 32'd8;   e_t3[3] = 32'd3;

        // T1 reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_vv", {63'd0, val_valid}, 64'd0);
        chk("t1_val", {32'd0, val}, 64'd0);
        chk("t1_ready", {63'd0, rng_ready}, 64'd0);
        step();
        ena = 1'b0; rst_n = 1'b1;
        repeat (3) begin @(negedge clk); chk("t1_ready_released", {63'd0, rng_ready}, 64'd0); step(); end
        load_table();
        ena = 1'b1;

        // T2 / T3
        send_timed(w_t2, 1'b1);
        pop_expect(e_t2);
        send_timed(w_t2, 1'b0);
        pop_expect(e_t3);

        // T4 backpressure
        rng_valid = 1'b1; rng = w_t2; signed_en = 1'b1; acc = 0;
        repeat (8) begin @(negedge clk); if (rng_ready) acc++; step(); end
        rng_valid = 1'b0;
        chk("t4_accepts", 64'(acc), 64'd2);
        @(negedge clk); chk("t4_ready_full", {63'd0, rng_ready}, 64'd0);
        repeat (3) begin extract = 1'b1; step(); extract = 1'b0; end
        @(negedge clk); chk("t4_ready_after3", {63'd0, rng_ready}, 64'd0);
        extract = 1'b1; step(); extract = 1'b0;
        @(negedge clk); chk("t4_ready_after4", {63'd0, rng_ready}, 64'd1);
        step();
        drain(n);
        chk("t4_rest", 64'(n), 64'd4);

        // T5a flush one cycle after accept
        rng_valid = 1'b1; rng = w_t2;
        step();
        rng_valid = 1'b0; clr = 1'b1; extract = 1'b1;
        @(negedge clk); chk("t5_ready_clr", {63'd0, rng_ready}, 64'd0);
        step();
        clr = 1'b0; extract = 1'b0;
        repeat (5) begin @(negedge clk); chk("t5_no_late", {63'd0, val_valid}, 64'd0); step(); end

        // T6 misuse
        tbl_we = 1'b1; tbl_addr = 5'd0; tbl_wdata = '0;
        step();
        tbl_we = 1'b0;
        send_timed(w_t2, 1'b1);
        pop_expect(e_t2);
        extract = 1'b1; repeat (3) step(); extract = 1'b0;
        @(negedge clk); chk("t6_empty_pop", {63'd0, val_valid}, 64'd0);
        step();
        rng_valid = 1'b1; rng = mk({24'h123456, 24'h654321, 24'h0F0F0F, 24'hF0F0F0}, 4'b0101);
        step(); step();
        ena = 1'b0;
        repeat (4) step();
        rng_valid = 1'b0;
        drain(n);
        chk("t6_ena_drop", 64'(n), 64'd8);
        ena = 1'b1;

        // T5b reset with 5 queued
        rng_valid = 1'b1; rng = w_t2;
        step(); step();
        rng_valid = 1'b0;
        repeat (3) step();
        extract = 1'b1; repeat (3) step(); extract = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_vv", {63'd0, val_valid}, 64'd0);
        chk("t5_rst_val", {32'd0, val}, 64'd0);
        step();
        ena = 1'b0; rst_n = 1'b1;
        step();
        load_table();

        // Randomized traffic, then a backpressure-heavy phase
        for (int c = 0; c < 4000; c++) begin
            rng_valid = ($urandom % 4) != 0;
            rng       = {$urandom, $urandom, $urandom, $urandom};
            signed_en = $urandom % 2;
            ena       = ($urandom % 16) != 0;
            clr       = ($urandom % 64) == 0;
            extract   = (c < 2000) ? (($urandom % 3) != 0) : (($urandom % 4) == 0);
            tbl_we    = ($urandom % 8) == 0;
            tbl_addr  = 5'($urandom % 32);
            tbl_wdata = SAMP_W'($urandom);
            step();
        end
        rng_valid = 1'b0; clr = 1'b0; tbl_we = 1'b0; ena = 1'b1; extract = 1'b1;
        repeat (12) step();
        extract = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
